// File: rtl/step_scheduler_if.sv
// Control and status bundle for step_scheduler: start/pause/stop commands in,
// tick/step pulses and sequence status out.
interface step_scheduler_if #(
  parameter int IDX_W = 8
);
  logic             start;
  logic             pause;
  logic             stop;
  logic [9:0]       period_ms;
  logic [IDX_W-1:0] num_steps;
  logic             tick_1ms;
  logic             step;
  logic [IDX_W-1:0] step_idx;
  logic             busy;
  logic             paused;
  logic             done;

  modport master (
    output start, pause, stop, period_ms, num_steps,
    input  tick_1ms, step, step_idx, busy, paused, done
  );

  modport slave (
    input  start, pause, stop, period_ms, num_steps,
    output tick_1ms, step, step_idx, busy, paused, done
  );
endinterface

// File: rtl/step_scheduler.sv
// Millisecond step scheduler: emits num_steps step pulses spaced period_ms apart,
// with pause/stop control and a 1 ms tick derived from a clk prescaler.
module step_scheduler #(
  parameter int CLK_DIV = 100000,
  parameter int IDX_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  step_scheduler_if.slave   bus
);
  localparam int PS_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t           state_reg, state_next;
  logic [PS_W-1:0]  ps_reg, ps_next;
  logic [9:0]       ms_reg, ms_next;
  logic [9:0]       period_reg, period_next;
  logic [IDX_W-1:0] nsteps_reg, nsteps_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [IDX_W-1:0] idx_inc;
  logic             zero_pend_reg, zero_pend_next;
  logic             tick_reg, tick_next;
  logic             step_reg, step_next;
  logic             done_reg, done_next;
  logic             busy_reg, busy_next;
  logic             paused_reg, paused_next;

  assign idx_inc = idx_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ps_reg        <= '0;
      ms_reg        <= '0;
      period_reg    <= '0;
      nsteps_reg    <= '0;
      idx_reg       <= '0;
      zero_pend_reg <= 1'b0;
      tick_reg      <= 1'b0;
      step_reg      <= 1'b0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      paused_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ps_reg        <= ps_next;
      ms_reg        <= ms_next;
      period_reg    <= period_next;
      nsteps_reg    <= nsteps_next;
      idx_reg       <= idx_next;
      zero_pend_reg <= zero_pend_next;
      tick_reg      <= tick_next;
      step_reg      <= step_next;
      done_reg      <= done_next;
      busy_reg      <= busy_next;
      paused_reg    <= paused_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ps_next        = ps_reg;
    ms_next        = ms_reg;
    period_next    = period_reg;
    nsteps_next    = nsteps_reg;
    idx_next       = idx_reg;
    tick_next      = 1'b0;
    step_next      = 1'b0;
    // A zero-length sequence reports done one cycle after it was accepted.
    done_next      = zero_pend_reg;
    zero_pend_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          period_next = (bus.period_ms == 10'd0) ? 10'd1 : bus.period_ms;
          nsteps_next = bus.num_steps;
          ps_next     = '0;
          ms_next     = '0;
          idx_next    = '0;
          if (bus.num_steps == '0) begin
            zero_pend_next = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN, PAUSE: begin
        if (bus.stop) begin
          state_next = IDLE;
        end else if (bus.pause) begin
          state_next = PAUSE;
        end else begin
          // Resuming counts on the same edge, so a pause costs only its own cycles.
          state_next = RUN;
          if (ps_reg == PS_MAX) begin
            ps_next   = '0;
            tick_next = 1'b1;
            if (ms_reg == period_reg - 10'd1) begin
              ms_next   = '0;
              step_next = 1'b1;
              idx_next  = idx_inc;
              if (idx_inc == nsteps_reg) begin
                done_next  = 1'b1;
                state_next = IDLE;
              end
            end else begin
              ms_next = ms_reg + 10'd1;
            end
          end else begin
            ps_next = ps_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next   = (state_next != IDLE);
    paused_next = (state_next == PAUSE);
  end

  assign bus.tick_1ms = tick_reg;
  assign bus.step     = step_reg;
  assign bus.step_idx = idx_reg;
  assign bus.busy     = busy_reg;
  assign bus.paused   = paused_reg;
  assign bus.done     = done_reg;
endmodule

// File: tb/tb_step_scheduler.sv
// Bench for step_scheduler: elapsed-time model checked every cycle, plus
// directed scenarios with hand-computed event edges.
module tb_step_scheduler;
  localparam int CLK_DIV = 4;
  localparam int IDX_W   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  step_scheduler_if #(.IDX_W(IDX_W)) bus();

  step_scheduler #(.CLK_DIV(CLK_DIV), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a sequence is "elapsed active cycles"; ticks and steps fall on multiples.
  bit m_run, m_pau, m_zp;
  int m_el, m_per, m_nst, m_idx;
  bit e_tick, e_step, e_busy, e_paused, e_done;
  int e_idx;

  always @(posedge clk) begin
    cyc++;
    e_tick = 0; e_step = 0; e_done = 0;
    if (rst) begin
      m_run = 0; m_pau = 0; m_zp = 0; m_idx = 0;
    end else if (!m_run && !m_pau) begin
      e_done = m_zp;
      m_zp = 0;
      if (bus.start) begin
        m_per = (bus.period_ms == 0) ? 1 : int'(bus.period_ms);
        m_nst = int'(bus.num_steps);
        m_el  = 0;
        m_idx = 0;
        if (m_nst == 0) m_zp = 1;
        else m_run = 1;
      end
    end else if (bus.stop) begin
      m_run = 0; m_pau = 0;
    end else if (bus.pause) begin
      m_run = 0; m_pau = 1;
    end else begin
      m_run = 1; m_pau = 0;
      m_el++;
      e_tick = (m_el % CLK_DIV) == 0;
      e_step = (m_el % (CLK_DIV * m_per)) == 0;
      if (e_step) begin
        m_idx = m_el / (CLK_DIV * m_per);
        if (m_idx == m_nst) begin
          e_done = 1;
          m_run  = 0;
        end
      end
    end
    e_busy   = m_run | m_pau;
    e_paused = m_pau;
    e_idx    = m_idx % (1 << IDX_W);
  end

  int tick_q[$], step_q[$], done_q[$], busy_q[$], pause_q[$];

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("tick_1ms", bus.tick_1ms, e_tick);
      chk("step", bus.step, e_step);
      chk("step_idx", bus.step_idx, e_idx);
      chk("busy", bus.busy, e_busy);
      chk("paused", bus.paused, e_paused);
      chk("done", bus.done, e_done);
      if (bus.tick_1ms) tick_q.push_back(cyc);
      if (bus.step)     step_q.push_back(cyc);
      if (bus.done)     done_q.push_back(cyc);
      if (bus.busy)     busy_q.push_back(cyc);
      if (bus.paused)   pause_q.push_back(cyc);
    end
  end

  task automatic clear_q();
    tick_q.delete(); step_q.delete(); done_q.delete(); busy_q.delete(); pause_q.delete();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns k, the edge at which start is sampled.
  task automatic start_seq(input int per, input int n, output int k);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.period_ms = 10'(per);
    bus.num_steps = IDX_W'(n);
    @(negedge clk);
    bus.start = 1'b0;
    k = cyc;
  endtask

  int k;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
    bus.period_ms = '0; bus.num_steps = '0;
    wait_cyc(3);
    chk("reset_busy", bus.busy, 0);
    chk("reset_idx", bus.step_idx, 0);
    chk("reset_done", bus.done, 0);
    rst = 1'b0;
    wait_cyc(2);

    // period 3, two steps
    clear_q();
    start_seq(3, 2, k);
    wait_cyc(40);
    chk("A_nsteps", step_q.size(), 2);
    if (step_q.size() == 2) begin
      chk("A_step0_edge", step_q[0], k + 12);
      chk("A_step1_edge", step_q[1], k + 24);
    end
    chk("A_ndone", done_q.size(), 1);
    if (done_q.size() == 1) chk("A_done_edge", done_q[0], k + 24);
    chk("A_nticks", tick_q.size(), 6);
    if (tick_q.size() > 0) chk("A_tick0_edge", tick_q[0], k + 4);
    chk("A_idx_final", bus.step_idx, 2);
    chk("A_busy_final", bus.busy, 0);

    // same, paused for edges k+5..k+14
    clear_q();
    start_seq(3, 2, k);
    wait_cyc(4);
    bus.pause = 1'b1;
    wait_cyc(10);
    bus.pause = 1'b0;
    wait_cyc(40);
    chk("B_npaused", pause_q.size(), 10);
    if (pause_q.size() > 0) chk("B_pause0_edge", pause_q[0], k + 5);
    if (tick_q.size() > 1) chk("B_tick1_edge", tick_q[1], k + 18);
    chk("B_nsteps", step_q.size(), 2);
    if (step_q.size() == 2) begin
      chk("B_step0_edge", step_q[0], k + 22);
      chk("B_step1_edge", step_q[1], k + 34);
    end
    if (done_q.size() == 1) chk("B_done_edge", done_q[0], k + 34);
    else chk("B_ndone", done_q.size(), 1);

    // stop at edge k+14
    clear_q();
    start_seq(3, 2, k);
    wait_cyc(13);
    bus.stop = 1'b1;
    wait_cyc(1);
    bus.stop = 1'b0;
    wait_cyc(30);
    chk("C_ndone", done_q.size(), 0);
    chk("C_nsteps", step_q.size(), 1);
    chk("C_nticks", tick_q.size(), 3);
    chk("C_idx", bus.step_idx, 1);
    chk("C_busy", bus.busy, 0);

    // period 0 behaves as 1 ms
    clear_q();
    start_seq(0, 3, k);
    wait_cyc(20);
    chk("D_nsteps", step_q.size(), 3);
    if (step_q.size() == 3) begin
      chk("D_step0_edge", step_q[0], k + 4);
      chk("D_step2_edge", step_q[2], k + 12);
    end
    if (done_q.size() == 1) chk("D_done_edge", done_q[0], k + 12);
    else chk("D_ndone", done_q.size(), 1);

    // zero steps
    clear_q();
    start_seq(5, 0, k);
    wait_cyc(5);
    chk("E_ndone", done_q.size(), 1);
    if (done_q.size() == 1) chk("E_done_edge", done_q[0], k + 1);
    chk("E_nbusy", busy_q.size(), 0);
    chk("E_nsteps", step_q.size(), 0);

    // start while busy is ignored
    clear_q();
    start_seq(2, 1, k);
    wait_cyc(2);
    bus.start = 1'b1; bus.period_ms = 10'd7; bus.num_steps = 8'd5;
    wait_cyc(1);
    bus.start = 1'b0;
    wait_cyc(20);
    chk("F_nsteps", step_q.size(), 1);
    if (step_q.size() == 1) chk("F_step_edge", step_q[0], k + 8);
    if (done_q.size() == 1) chk("F_done_edge", done_q[0], k + 8);
    else chk("F_ndone", done_q.size(), 1);

    // reset mid-run together with stop and pause
    clear_q();
    start_seq(3, 2, k);
    wait_cyc(13);
    rst = 1'b1; bus.stop = 1'b1; bus.pause = 1'b1;
    wait_cyc(1);
    chk("G_busy", bus.busy, 0);
    chk("G_paused", bus.paused, 0);
    chk("G_idx", bus.step_idx, 0);
    chk("G_tick", bus.tick_1ms, 0);
    chk("G_step", bus.step, 0);
    chk("G_done", bus.done, 0);
    rst = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    clear_q();
    start_seq(1, 1, k);
    wait_cyc(10);
    chk("G_nsteps", step_q.size(), 1);
    if (step_q.size() == 1) chk("G_step_edge", step_q[0], k + 4);
    if (done_q.size() == 1) chk("G_done_edge", done_q[0], k + 4);
    else chk("G_ndone", done_q.size(), 1);
    chk("G_idx_final", bus.step_idx, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/step_scheduler.md
STEP_SCHEDULER -- requirements
Module: step_scheduler

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100000, giving clk cycles per 1 ms tick.
REQ-002 SHALL have parameter IDX_W, default 8, giving the width of the step count and index.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin a sequence; honoured only in IDLE.
REQ-006 SHALL have port pause, input, 1 bit: level signal; while high, a running sequence is frozen.
REQ-007 SHALL have port stop, input, 1 bit: aborts a running or paused sequence.
REQ-008 SHALL have port period_ms, input, 10 bits: step period in ms, captured when start is accepted.
REQ-009 SHALL have port num_steps, input, IDX_W bits: number of steps, captured when start is accepted.
REQ-010 SHALL have port tick_1ms, output, 1 bit: one-cycle pulse per elapsed ms while running.
REQ-011 SHALL have port step, output, 1 bit: one-cycle pulse per completed step period.
REQ-012 SHALL have port step_idx, output, IDX_W bits: count of steps emitted in the current or last sequence.
REQ-013 SHALL have port busy, output, 1 bit: high in RUN or PAUSE.
REQ-014 SHALL have port paused, output, 1 bit: high in PAUSE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse when a sequence completes normally.

Function
REQ-016 SHALL implement an FSM with states IDLE, RUN and PAUSE; all outputs SHALL be registered.
REQ-017 SHALL, in IDLE on an edge with start=1, capture period_ms (a value of 0 stored as 1) and num_steps, clear the prescaler, ms counter and step_idx, and enter RUN.
REQ-018 SHALL, if num_steps=0 when start is accepted, pulse done in the next cycle, emit no step or tick, and remain in IDLE.
REQ-019 SHALL, in RUN, increment the prescaler every cycle, wrapping from CLK_DIV-1 to 0; the wrap edge SHALL set tick_1ms high for exactly the following cycle.
REQ-020 SHALL, on each wrap edge, increment the ms counter; when the ms counter equals period-1, it SHALL clear instead, assert step for the following cycle (coincident with tick_1ms), and increment step_idx on the same edge.
REQ-021 SHALL, when the increment makes step_idx equal the captured num_steps, also assert done in the same cycle as that final step and return to IDLE on the same edge, so busy is low in that cycle.
REQ-022 SHALL, in RUN with pause=1, enter PAUSE, freeze the prescaler, ms counter and step_idx, and emit no tick_1ms or step.
REQ-023 SHALL, in PAUSE with pause=0, resume RUN from the frozen counts, so paused time adds no latency other than the cycles spent paused.
REQ-024 SHALL, on stop=1 in RUN or PAUSE, go to IDLE on that edge with no done pulse; step_idx holds its last value.
REQ-025 SHALL apply the priority rst > stop > pause > counting; start SHALL be ignored outside IDLE.
REQ-026 SHALL ignore pause and stop in IDLE.
REQ-027 SHALL compute step_idx modulo 2^IDX_W and the prescaler with width ceil(log2(CLK_DIV)) or more; no counter SHALL overflow for CLK_DIV>=2.

Reset
REQ-028 SHALL, on rst=1 at a clock edge in any state, go to IDLE and clear prescaler, ms counter, step_idx, tick_1ms, step, busy, paused and done to 0.
REQ-029 SHALL discard an in-progress sequence on rst, with no done pulse; the first start after rst is deasserted SHALL behave per REQ-017.

Verification (CLK_DIV=4; start accepted at edge k)
REQ-030 SHALL cover: period_ms=3, num_steps=2 -> tick_1ms high after edges k+4, k+8, ...; step after k+12 and k+24; step_idx 1 then 2; done coincident with the second step; busy low from then on.
REQ-031 SHALL cover: the REQ-030 setup with pause held high for 10 cycles starting at edge k+5 -> every later tick, step and done delayed by exactly 10 cycles; paused=1 throughout the pause.
REQ-032 SHALL cover: stop pulsed at edge k+14 -> busy=0 afterwards, no done, step_idx stays 1, and no further ticks.
REQ-033 SHALL cover: period_ms=0, num_steps=3 -> a step on every tick (after k+4, k+8, k+12) and done after k+12.
REQ-034 SHALL cover: num_steps=0 -> done for 1 cycle after edge k+1, busy never high; a start pulse while busy -> ignored, with the captured period unchanged.
REQ-035 SHALL cover: rst asserted mid-RUN, simultaneously with stop and pause -> all outputs 0 on the next cycle, and a subsequent start restarts cleanly.
